rx_data_buffer: RTL

RX_DATA_BUFFER -- requirements
Module: rx_data_buffer

---
 rtl/usb_rx_pkg.sv | 14 +
 rtl/rx_buffer_mem.sv | 26 ++
 rtl/rx_data_buffer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive path: packet-state encoding and
// default receive-buffer depth.
package usb_rx_pkg;

  localparam int RX_BUF_DEPTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    PIDLE = 2'd0,
    PRCV  = 2'd1,
    PDONE = 2'd2,
    PERR  = 2'd3
  } pkt_state_e;

endpackage

// File: rtl/rx_buffer_mem.sv
// Receive-buffer storage: register array with one write port and a
// combinational read port. Contents are intentionally not reset.
module rx_buffer_mem
  import usb_rx_pkg::*;
#(
  parameter int DEPTH  = RX_BUF_DEPTH_DEFAULT,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_data_buffer.sv
// Receive data buffer: first-word-fall-through circular byte FIFO with a
// packet-status FSM. Optional sticky overrun flag via RX_BUFFER_OVERRUN_DET_EN.
module rx_data_buffer
  import usb_rx_pkg::*;
#(
  parameter int DEPTH = RX_BUF_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     w_enable,
  input  logic [7:0]               rcv_data,
  input  logic                     rcving,
  input  logic                     r_error,
  input  logic                     get_rx_data,
  input  logic                     flush,
  output logic [7:0]               rx_data,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty,
  output logic                     pkt_done,
  output logic                     pkt_error,
  output logic                     overrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  pkt_state_e    state_q, state_d;
  logic          pkt_error_q, pkt_error_d;
  logic          rcving_q;
  logic [7:0]    head_byte;
  logic          pop, wr_acc, mem_we;
  logic          rcv_rise, rcv_fall;

  assign full   = (occ_q == OW'(DEPTH));
  assign empty  = (occ_q == '0);
  assign pop    = get_rx_data && !empty;
  // At full a write is only admitted if a pop frees the head slot this cycle.
  assign wr_acc = w_enable && (!full || get_rx_data);
  assign mem_we = wr_acc && !flush;

  rx_buffer_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (8)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (rcv_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_byte)
  );

  assign rx_data   = empty ? 8'h00 : head_byte;
  assign occupancy = occ_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (pop)    rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      if (wr_acc) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      case ({wr_acc, pop})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  assign rcv_rise = rcving && !rcving_q;
  assign rcv_fall = !rcving && rcving_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      PIDLE:   if (rcv_rise) state_d = PRCV;
      PRCV: begin
        if (r_error)       state_d = PERR;
        else if (rcv_fall) state_d = PDONE;
      end
      PDONE:   state_d = PIDLE;
      PERR:    if (rcv_rise) state_d = PRCV;
      default: state_d = PIDLE;
    endcase
    if (flush) state_d = PIDLE;
  end

  // Error is raised on entering PERR and withdrawn when the next packet starts.
  always_comb begin
    pkt_error_d = pkt_error_q;
    if (flush)                                 pkt_error_d = 1'b0;
    else if (state_d == PERR && state_q != PERR) pkt_error_d = 1'b1;
    else if (rcv_rise)                         pkt_error_d = 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
      state_q     <= PIDLE;
      pkt_error_q <= 1'b0;
      rcving_q    <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      state_q     <= state_d;
      pkt_error_q <= pkt_error_d;
      rcving_q    <= rcving;
    end
  end

  assign pkt_done  = (state_q == PDONE);
  assign pkt_error = pkt_error_q;

`ifdef RX_BUFFER_OVERRUN_DET_EN
  logic overrun_q;
  logic drop;

  assign drop = w_enable && full && !get_rx_data;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)     overrun_q <= 1'b0;
    else if (flush) overrun_q <= 1'b0;
    else if (drop)  overrun_q <= 1'b1;
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule
